pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the 16-bit program counter; sequences opcode fetch, the two operand-byte fetches of jump
//  instructions, and resolution of the jump unit's condition (taken/not-taken, absolute/relative).
//  Sits between program memory and the jump unit: drives its databus/pcc/oe/pcin, consumes pcoe/pcout.
//  Non-jump opcodes are handed to the execute stage via ins/ins_valid.
// PARAMETERS
//  RESET_VEC    16'h0000  PC value after reset
//  STACK_DEPTH  4         return-address entries (CALL_STACK_EN only; power of 2, >=2)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  mem_req      out  1   program-memory read request
//  mem_addr     out  16  read address (= pc while mem_req)
//  mem_ack      in   1   read data valid this cycle; ignored when mem_req=0
//  mem_data     in   8   read data
//  is_jmp       in   1   decode: ins is a jump-class opcode (comb. from ins)
//  is_call      in   1   decode: ins is a call (jump that pushes return addr)
//  is_ret       in   1   decode: ins is a return
//  exec_done    in   1   execute stage finished current non-jump ins
//  ins          out  8   current opcode (to decode / jump unit cins)
//  ins_valid    out  1   ins handed to execute stage
//  jmp_data     out  8   jump-unit databus
//  jmp_pcc      out  1   jump-unit high-byte latch strobe
//  jmp_oe       out  1   jump-unit output enable
//  jmp_taken    in   1   jump-unit pcoe
//  jmp_target   in   16  jump-unit pcout
//  pc           out  16  program counter (also jump-unit pcin)
//  stack_err    out  1   sticky stack over/underflow flag
// BEHAVIOUR
//  Reset (any state, overrides everything): state=FETCH, pc=RESET_VEC, ins=0, data_q=0, stack
//   empty, stack_err=0. All strobes are 0 in reset cycle; in-flight mem_ack dropped.
//  States: FETCH, DECODE, EXEC, HI, LO, RESOLVE.
//  FETCH: mem_req=1. On mem_ack: ins<=mem_data, pc<=pc+1, ->DECODE. Else hold.
//  DECODE (1 cycle): is_ret (CALL_STACK_EN) -> pop, ->FETCH; is_jmp -> HI; else -> EXEC.
//  EXEC: ins_valid=1; on exec_done ->FETCH (min 1 cycle; exec_done outside EXEC ignored).
//  HI: mem_req=1; jmp_data=mem_data (comb); jmp_pcc=mem_ack. On ack: pc<=pc+1, ->LO.
//  LO: mem_req=1. On ack: data_q<=mem_data, pc<=pc+1, ->RESOLVE.
//  RESOLVE (1 cycle): jmp_oe=1, jmp_data=data_q, pc = addr after operands (relative base).
//   jmp_taken=1: pc<=jmp_target (is_call: push pc first). jmp_taken=0: pc unchanged. ->FETCH.
//  jmp_data=data_q in all states except HI; jmp_pcc=0 except HI&mem_ack; jmp_oe=0 except RESOLVE.
//  Latency, zero-wait memory: non-jump 3+ cycles; jump 5 cycles FETCH->next FETCH.
//  Arithmetic: pc increments mod 2^16 (16'hFFFF -> 16'h0000); target taken verbatim.
//  mem_addr=pc whenever mem_req=1, else 0. ins holds from FETCH ack until next FETCH ack.
// CONFIGURATION
//  CALL_STACK_EN defined: STACK_DEPTH x 16 LIFO. Push in RESOLVE when is_call&jmp_taken;
//   pop in DECODE when is_ret (pc<=top). Push when full: oldest entry overwritten, stack_err<=1.
//   Pop when empty: pc<=RESET_VEC, stack_err<=1. stack_err sticky until rst.
//  CALL_STACK_EN undefined: no storage; is_call/is_ret ignored (ret decodes per is_jmp/else),
//   stack_err tied 0.
// TESTING
//  1 rst, mem 0000:=non-jump, exec_done 1 cyc later -> ins_valid 1 cycle, pc=0001, back to FETCH.
//  2 jump at 0010, operands 12,34, jmp_taken=1, target=1234 -> pcc on HI ack w/ data 12,
//    oe only in RESOLVE, data 34 there, next mem_addr=1234; taken=0 -> next mem_addr=0013.
//  3 mem_ack held low 5 cycles in HI -> no pcc, pc frozen, mem_req held; resumes on ack.
//  4 pc=FFFF non-jump fetch -> pc wraps to 0000; rst asserted during LO -> next cycle FETCH at
//    RESET_VEC, oe/pcc 0, late mem_ack ignored.
//  5 CALL_STACK_EN: call at 0020 -> 0100, ret -> pc=0023; 5 nested calls (depth 4) -> stack_err=1;
//    ret on empty -> pc=RESET_VEC, stack_err stays 1 until rst.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner: sequences opcode fetch, jump operand fetch and jump resolution.
// Define CALL_STACK_EN to add the STACK_DEPTH-entry return-address LIFO used by call/return.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC   = 16'h0000,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        is_jmp,
  input  logic        is_call,
  input  logic        is_ret,
  input  logic        exec_done,
  output logic [7:0]  ins,
  output logic        ins_valid,
  output logic [7:0]  jmp_data,
  output logic        jmp_pcc,
  output logic        jmp_oe,
  input  logic        jmp_taken,
  input  logic [15:0] jmp_target,
  output logic [15:0] pc,
  output logic        stack_err
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_HI      = 3'd3;
  localparam logic [2:0] S_LO      = 3'd4;
  localparam logic [2:0] S_RESOLVE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ins_q, ins_d;
  logic [7:0]  data_q, data_d;
  logic        ret_hit, call_hit;
  logic        push, pop;
  logic        stack_empty;
  logic [15:0] stack_top;

  // Strobes are masked during the reset cycle regardless of the state register.
  assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_HI || state_q == S_LO);
  assign mem_addr  = mem_req ? pc_q : 16'h0000;
  assign ins       = ins_q;
  assign ins_valid = !rst && (state_q == S_EXEC);
  assign jmp_data  = (state_q == S_HI) ? mem_data : data_q;
  assign jmp_pcc   = mem_req && (state_q == S_HI) && mem_ack;
  assign jmp_oe    = !rst && (state_q == S_RESOLVE);
  assign pc        = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    data_d  = data_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ins_d   = mem_data;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ret_hit) begin
          pop     = 1'b1;
          pc_d    = stack_empty ? RESET_VEC : stack_top;
          state_d = S_FETCH;
        end else if (is_jmp) begin
          state_d = S_HI;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_FETCH;
      end
      S_HI: begin
        if (mem_ack) begin
          pc_d    = pc_q + 16'd1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (mem_ack) begin
          data_d  = mem_data;
          pc_d    = pc_q + 16'd1;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        // pc_q already points past the operands: that is the return address and relative base.
        if (jmp_taken) begin
          pc_d = jmp_target;
          push = call_hit;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VEC;
      ins_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      data_q  <= data_d;
    end
  end

`ifdef CALL_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH);

  logic [15:0]   stk_q [STACK_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   cnt_q;
  logic          err_q;

  assign ret_hit     = is_ret;
  assign call_hit    = is_call;
  assign stack_empty = (cnt_q == '0);
  assign stack_top   = stk_q[wr_ptr_q - PW'(1)];
  assign stack_err   = err_q;

  // Circular buffer: when full, the write pointer sits on the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (push) begin
      stk_q[wr_ptr_q] <= pc_q;
      wr_ptr_q        <= wr_ptr_q + PW'(1);
      if (cnt_q == (PW+1)'(STACK_DEPTH)) err_q <= 1'b1;
      else                               cnt_q <= cnt_q + (PW+1)'(1);
    end else if (pop) begin
      if (stack_empty) begin
        err_q <= 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_q - PW'(1);
        cnt_q    <= cnt_q - (PW+1)'(1);
      end
    end
  end
`else
  logic unused_stack;

  assign ret_hit      = 1'b0;
  assign call_hit     = 1'b0;
  assign stack_empty  = 1'b1;
  assign stack_top    = RESET_VEC;
  assign stack_err    = 1'b0;
  assign unused_stack = ^{is_call, is_ret, push, pop};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: instruction-level reference model checked every cycle,
// plus hand-computed cycle-exact expectations along the directed program.
module tb_pc_sequencer;
  localparam logic [15:0] RV    = 16'h0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, is_jmp, is_call, is_ret, exec_done;
  logic        ins_valid, jmp_pcc, jmp_oe, jmp_taken, stack_err;
  logic [15:0] mem_addr, jmp_target, pc;
  logic [7:0]  mem_data, ins, jmp_data;
  logic        ack_en, exec_en, taken_v;
  logic [7:0]  prog [0:65535];
  logic [7:0]  hi_q = 8'h00;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic f_jmp(input logic [7:0] op);
    return op[7:4] == 4'hC;
  endfunction
  function automatic logic f_call(input logic [7:0] op);
    return op == 8'hCD;
  endfunction
  function automatic logic f_ret(input logic [7:0] op);
    return op == 8'hE9;
  endfunction

  assign mem_ack    = ack_en;
  assign mem_data   = prog[mem_addr];
  assign is_jmp     = f_jmp(ins);
  assign is_call    = f_call(ins);
  assign is_ret     = f_ret(ins);
  assign exec_done  = exec_en;
  assign jmp_taken  = taken_v;
  // Absolute-mode jump unit: high byte latched on pcc, low byte straight from the databus.
  assign jmp_target = {hi_q, jmp_data};
  always @(posedge clk) if (jmp_pcc) hi_q <= jmp_data;

  pc_sequencer #(.RESET_VEC(RV), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .is_jmp(is_jmp), .is_call(is_call), .is_ret(is_ret),
    .exec_done(exec_done), .ins(ins), .ins_valid(ins_valid), .jmp_data(jmp_data),
    .jmp_pcc(jmp_pcc), .jmp_oe(jmp_oe), .jmp_taken(jmp_taken), .jmp_target(jmp_target),
    .pc(pc), .stack_err(stack_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic [15:0] a, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      hit = mem_req && (mem_addr == a);
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  // Reference model: walks the program one memory read at a time (opcode, operand hi, operand lo)
  // and predicts addresses, strobes and the return stack at the instruction level.
  logic [15:0] m_addr = RV;
  logic [15:0] m_stk [$];
  logic [7:0]  m_ins = 8'h00;
  logic [7:0]  m_lo = 8'h00;
  int          m_kind = 0;
  bit          m_pend = 1'b0;
  bit          m_retp = 1'b0;
  bit          m_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pcc", 32'(jmp_pcc), 32'd0);
        chk("rst_oe", 32'(jmp_oe), 32'd0);
        chk("rst_ivld", 32'(ins_valid), 32'd0);
        m_addr = RV; m_kind = 0; m_pend = 1'b0; m_retp = 1'b0;
        m_err = 1'b0; m_ins = 8'h00; m_lo = 8'h00;
        m_stk.delete();
      end else begin
        chk("m_pc", 32'(pc), 32'(m_addr));
        chk("m_addr", 32'(mem_addr), mem_req ? 32'(m_addr) : 32'd0);
        chk("m_pcc", 32'(jmp_pcc), 32'(mem_req && mem_ack && m_kind == 1));
        chk("m_data", 32'(jmp_data), (m_kind == 1 && mem_req) ? 32'(mem_data) : 32'(m_lo));
        chk("m_oe", 32'(jmp_oe), 32'(m_pend));
        chk("m_ins", 32'(ins), 32'(m_ins));
        chk("m_err", 32'(stack_err), 32'(m_err));
        if (ins_valid)
          chk("m_ivld", 32'(m_kind == 0 && !m_pend && !m_retp && !f_jmp(m_ins)), 32'd1);
        if (m_pend || m_retp) chk("m_noreq", 32'(mem_req), 32'd0);
        if (m_retp) begin
          if (m_stk.size() == 0) begin
            m_addr = RV;
            m_err  = 1'b1;
          end else begin
            m_addr = m_stk.pop_back();
          end
          m_retp = 1'b0;
        end else if (mem_req && mem_ack) begin
          m_addr = m_addr + 16'd1;
          if (m_kind == 0) begin
            m_ins = mem_data;
`ifdef CALL_STACK_EN
            if (f_ret(mem_data)) m_retp = 1'b1;
            else if (f_jmp(mem_data)) m_kind = 1;
`else
            if (f_jmp(mem_data)) m_kind = 1;
`endif
          end else if (m_kind == 1) begin
            m_kind = 2;
          end else begin
            m_lo   = mem_data;
            m_pend = 1'b1;
            m_kind = 0;
          end
        end else if (m_pend) begin
          if (jmp_taken) begin
`ifdef CALL_STACK_EN
            if (f_call(m_ins)) begin
              if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_err = 1'b1;
              end
              m_stk.push_back(m_addr);
            end
`endif
            m_addr = jmp_target;
          end
          m_pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) prog[i] = 8'h00;
    prog[16'h0001] = 8'hC3; prog[16'h0002] = 8'h00; prog[16'h0003] = 8'h10;
    prog[16'h0010] = 8'hC3; prog[16'h0011] = 8'h12; prog[16'h0012] = 8'h34;
    prog[16'h0013] = 8'hC3; prog[16'h0014] = 8'hFF; prog[16'h0015] = 8'hFF;
    prog[16'h1234] = 8'hC3; prog[16'h1235] = 8'h00; prog[16'h1236] = 8'h10;
    rst = 1'b1; ack_en = 1'b1; exec_en = 1'b1; taken_v = 1'b1;
    step(); step();
    rst = 1'b0; #1;
    // Reset state, then a non-jump at 0000.
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_ins", 32'(ins), 32'h00);
    chk("rst_err", 32'(stack_err), 32'd0);
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h0000);
    step();
    chk("t1_dec_pc", 32'(pc), 32'h0001);
    chk("t1_dec_ivld", 32'(ins_valid), 32'd0);
    step();
    chk("t1_exec_ivld", 32'(ins_valid), 32'd1);
    chk("t1_exec_req", 32'(mem_req), 32'd0);
    step();
    chk("t1_refetch", 32'(mem_addr), 32'h0001);
    chk("t1_ivld_once", 32'(ins_valid), 32'd0);
    // Jump at 0001 -> 0010, then jump at 0010 with operands 12,34.
    step(); step();
    chk("t2a_pcc", 32'(jmp_pcc), 32'd1);
    step(); step();
    chk("t2a_oe", 32'(jmp_oe), 32'd1);
    chk("t2a_pc", 32'(pc), 32'h0004);
    step();
    chk("t2a_target", 32'(mem_addr), 32'h0010);
    step(); step();
    chk("t2_hi_addr", 32'(mem_addr), 32'h0011);
    chk("t2_hi_pcc", 32'(jmp_pcc), 32'd1);
    chk("t2_hi_data", 32'(jmp_data), 32'h12);
    chk("t2_hi_oe", 32'(jmp_oe), 32'd0);
    step();
    chk("t2_lo_addr", 32'(mem_addr), 32'h0012);
    chk("t2_lo_pcc", 32'(jmp_pcc), 32'd0);
    step();
    chk("t2_res_oe", 32'(jmp_oe), 32'd1);
    chk("t2_res_data", 32'(jmp_data), 32'h34);
    chk("t2_res_pc", 32'(pc), 32'h0013);
    step();
    chk("t2_taken_addr", 32'(mem_addr), 32'h1234);
    chk("t2_taken_oe", 32'(jmp_oe), 32'd0);
    // 1234 jumps back to 0010; HI of that jump waits 5 cycles for memory.
    step(); step(); step(); step(); step();
    chk("t3_back_addr", 32'(mem_addr), 32'h0010);
    step();
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_wait_req", 32'(mem_req), 32'd1);
      chk("t3_wait_pcc", 32'(jmp_pcc), 32'd0);
      chk("t3_wait_pc", 32'(pc), 32'h0011);
    end
    step();
    ack_en = 1'b1; #1;
    chk("t3_resume_pcc", 32'(jmp_pcc), 32'd1);
    step();
    taken_v = 1'b0;
    step();
    chk("t2_nt_oe", 32'(jmp_oe), 32'd1);
    step();
    taken_v = 1'b1; #1;
    chk("t2_nt_addr", 32'(mem_addr), 32'h0013);
    // Jump at 0013 -> FFFF; the fetch there wraps pc to 0000; execute lasts two cycles.
    step(); step(); step(); step(); step();
    chk("t4_ffff_addr", 32'(mem_addr), 32'hFFFF);
    step();
    exec_en = 1'b0; #1;
    chk("t4_wrap_pc", 32'(pc), 32'h0000);
    step();
    chk("t4_exec1", 32'(ins_valid), 32'd1);
    step();
    exec_en = 1'b1; #1;
    chk("t4_exec2", 32'(ins_valid), 32'd1);
    step();
    chk("t4_fetch0", 32'(mem_addr), 32'h0000);
    chk("t4_fetch0_req", 32'(mem_req), 32'd1);
    // 0000 non-jump, then jump at 0001; reset lands in its LO cycle with ack still high.
    step(); step(); step(); step(); step(); step();
    chk("t4_lo_addr", 32'(mem_addr), 32'h0003);
    rst = 1'b1; #1;
    chk("t4_rst_req", 32'(mem_req), 32'd0);
    chk("t4_rst_addr", 32'(mem_addr), 32'h0000);
    step();
    rst = 1'b0; #1;
    chk("t4_post_req", 32'(mem_req), 32'd1);
    chk("t4_post_addr", 32'(mem_addr), 32'(RV));
    chk("t4_post_ins", 32'(ins), 32'h00);
    chk("t4_post_data", 32'(jmp_data), 32'h00);
    chk("t4_post_oe", 32'(jmp_oe), 32'd0);
`ifdef CALL_STACK_EN
    rst = 1'b1;
    step();
    prog[16'h0000] = 8'hC3; prog[16'h0001] = 8'h00; prog[16'h0002] = 8'h20;
    prog[16'h0020] = 8'hCD; prog[16'h0021] = 8'h01; prog[16'h0022] = 8'h00;
    prog[16'h0100] = 8'hE9;
    prog[16'h0023] = 8'hCD; prog[16'h0024] = 8'h02; prog[16'h0025] = 8'h00;
    for (int k = 2; k <= 5; k++) begin
      prog[{8'(k), 8'h00}] = 8'hCD;
      prog[{8'(k), 8'h01}] = 8'(k + 1);
      prog[{8'(k), 8'h02}] = 8'h00;
      prog[{8'(k), 8'h03}] = 8'hE9;
    end
    prog[16'h0600] = 8'hE9;
    step();
    rst = 1'b0;
    wait_req(16'h0020, "t5_call_site");
    wait_req(16'h0100, "t5_call_target");
    wait_req(16'h0023, "t5_ret_addr");
    chk("t5_ret_pc", 32'(pc), 32'h0023);
    chk("t5_err_clear", 32'(stack_err), 32'd0);
    wait_req(16'h0600, "t5_fifth_call");
    chk("t5_overflow", 32'(stack_err), 32'd1);
    wait_req(16'h0000, "t5_empty_ret");
    chk("t5_err_sticky", 32'(stack_err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("t5_err_rst", 32'(stack_err), 32'd0);
`endif
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
